// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the moore_t sequencer.
// The optional in-line checker is enabled by defining SEQ_CHECK_EN.
package moore_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int SEQ_DRAIN_CYCLES = 2;
    localparam int SEQ_DEFAULT_N    = 16;

endpackage

// File: rtl/tff_ref_model.sv
// Expected-z generator: a toggle register cleared by clr that flips when en and t are both high.
module tff_ref_model (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en && t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/moore_t_sequencer.sv
// Sequences a moore_t toggle FSM: clear it, drive a latched x pattern, capture the z stream.
// Defining SEQ_CHECK_EN builds a reference toggle model that flags any captured bit mismatch.
module moore_t_sequencer
    import moore_seq_pkg::*;
#(
    parameter int N     = SEQ_DEFAULT_N,
    parameter int LEN_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     pattern,
    input  logic [LEN_W-1:0] len,
    output logic             dut_reset,
    output logic             x,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     z_capture,
    output logic             mismatch
);

    localparam logic [LEN_W-1:0] N_LEN      = LEN_W'(N);
    localparam logic [1:0]       DRAIN_LAST = 2'(SEQ_DRAIN_CYCLES - 1);

    seq_state_t       state_reg, state_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic [1:0]       drain_reg, drain_next;
    logic [N-1:0]     pat_reg;
    logic [LEN_W-1:0] len_reg, len_sat;
    logic             accept;
    logic [N-1:0]     x_shift;
    logic             x_reg, x_next;
    logic             dut_reset_reg, busy_reg, done_reg;

    // Two-stage tracker: stage 1 lines up with the z response of the tracked bit.
    logic             v0_reg, v1_reg;
    logic [LEN_W-1:0] idx0_reg, idx1_reg;
    logic [N-1:0]     cap_we;
    logic [N-1:0]     z_capture_reg;

    assign len_sat = (len > N_LEN) ? N_LEN : len;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        drain_next = drain_reg;
        accept     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                idx_next   = '0;
                state_next = (len_reg != '0) ? ST_DRIVE : ST_DONE;
            end
            ST_DRIVE: begin
                if (idx_reg == len_reg - LEN_W'(1)) begin
                    drain_next = '0;
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx_reg + LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        x_shift = pat_reg >> idx_next;
        x_next  = (state_next == ST_DRIVE) && x_shift[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            drain_reg     <= '0;
            pat_reg       <= '0;
            len_reg       <= '0;
            x_reg         <= 1'b0;
            dut_reset_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            idx0_reg      <= '0;
            idx1_reg      <= '0;
            z_capture_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            drain_reg     <= drain_next;
            x_reg         <= x_next;
            dut_reset_reg <= (state_next == ST_CLR);
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= (state_next == ST_DONE);
            v0_reg        <= (state_next == ST_DRIVE);
            idx0_reg      <= idx_next;
            v1_reg        <= v0_reg;
            idx1_reg      <= idx0_reg;
            if (accept) begin
                pat_reg       <= pattern;
                len_reg       <= len_sat;
                z_capture_reg <= '0;
            end else begin
                z_capture_reg <= (z_capture_reg & ~cap_we) | (cap_we & {N{z}});
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_cap_we
        assign cap_we[gi] = v1_reg && (idx1_reg == LEN_W'(gi));
    end

`ifdef SEQ_CHECK_EN
    logic bit0_reg;
    logic q_exp;
    logic mismatch_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit0_reg     <= 1'b0;
            mismatch_reg <= 1'b0;
        end else begin
            bit0_reg <= x_next;
            if (accept) begin
                mismatch_reg <= 1'b0;
            end else if (v1_reg && (z != q_exp)) begin
                mismatch_reg <= 1'b1;
            end
        end
    end

    // Model consumes each bit one edge after it is driven, matching moore_t's sampling point.
    tff_ref_model u_ref (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == ST_CLR),
        .en    (v0_reg),
        .t     (bit0_reg),
        .q     (q_exp)
    );

    assign mismatch = mismatch_reg;
`else
    assign mismatch = 1'b0;
`endif

    assign x         = x_reg;
    assign dut_reset = dut_reset_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign z_capture = z_capture_reg;

endmodule

// File: tb/tb_moore_t_sequencer.sv
// Self-checking bench for moore_t_sequencer with a behavioural moore_t toggle FSM attached.
module tb_moore_t_sequencer;

    localparam int N     = 16;
    localparam int LEN_W = $clog2(N + 1);
    localparam int BUDGET = 60;
`ifdef SEQ_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N-1:0]     pattern;
    logic [LEN_W-1:0] len;
    logic             dut_reset, x, z, busy, done, mismatch;
    logic [N-1:0]     z_capture;

    moore_t_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .dut_reset (dut_reset),
        .x         (x),
        .z         (z),
        .busy      (busy),
        .done      (done),
        .z_capture (z_capture),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Behavioural moore_t: state toggles on x=1, z is the state; inject flips z for fault tests.
    logic t_state;
    logic inject = 1'b0;
    always @(posedge clk or posedge dut_reset or posedge reset) begin
        if (dut_reset || reset) t_state <= 1'b0;
        else if (x)             t_state <= ~t_state;
    end
    assign z = t_state ^ inject;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Observations of the most recent run.
    int           obs_cycles;
    int           obs_rst_cycles;
    logic         obs_x_ok;
    logic         obs_timeout;
    logic [N-1:0] obs_zc, obs_zc0;
    logic         obs_mm, obs_mm0;

    function automatic int ref_len(int l);
        return (l > N) ? N : l;
    endfunction

    function automatic int ref_cycles(int l);
        return (ref_len(l) == 0) ? 2 : ref_len(l) + 4;
    endfunction

    // Bit i of the capture is the toggle state after consuming pattern bits 0..i.
    function automatic logic [N-1:0] ref_capture(logic [N-1:0] pat, int l);
        logic [N-1:0] res = '0;
        logic acc = 1'b0;
        for (int i = 0; i < ref_len(l); i++) begin
            acc    = acc ^ pat[i];
            res[i] = acc;
        end
        return res;
    endfunction

    // Expected x in cycle k after the accepting edge (cycle 1 is the clear cycle).
    function automatic logic ref_x(logic [N-1:0] pat, int l, int k);
        if (k >= 2 && k <= ref_len(l) + 1) return pat[k-2];
        return 1'b0;
    endfunction

    task automatic run_seq(input logic [N-1:0] pat, input int l, input logic [N-1:0] pat_after,
                           input bit hold_start, input int inject_cycle);
        @(negedge clk);
        pattern = pat;
        len     = LEN_W'(l);
        start   = 1'b1;
        @(posedge clk);
        obs_cycles = 0; obs_rst_cycles = 0; obs_x_ok = 1'b1; obs_timeout = 1'b1;
        obs_zc = 'x; obs_mm = 1'bx;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 1) begin
                obs_zc0 = z_capture;
                obs_mm0 = mismatch;
                pattern = pat_after;
                if (!hold_start) start = 1'b0;
            end
            if (x !== ref_x(pat, l, k)) obs_x_ok = 1'b0;
            if (dut_reset === 1'b1) obs_rst_cycles++;
            inject = (k == inject_cycle);
            if (done === 1'b1) begin
                obs_cycles  = k;
                obs_zc      = z_capture;
                obs_mm      = mismatch;
                obs_timeout = 1'b0;
                break;
            end
        end
        inject = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if ({busy, done, x, dut_reset, mismatch} !== 5'b0)
            $display("FAIL reset_outputs: got busy/done/x/dut_reset/mismatch=%b want 00000",
                     {busy, done, x, dut_reset, mismatch});
        else pass_cnt++;
        check_cnt++;
        if (z_capture !== '0) $display("FAIL reset_zcap: got %h want 0", z_capture);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_nominal();
        logic [N-1:0] pat = 16'h002D;
        run_seq(pat, 6, 16'hFFFF, 1'b0, 0);
        check_cnt++;
        if (obs_timeout || obs_cycles !== 10) $display("FAIL nominal_cycles: got %0d want 10", obs_cycles);
        else pass_cnt++;
        check_cnt++;
        if (obs_zc !== 16'h001B) $display("FAIL nominal_zcap: got %h want 001b", obs_zc);
        else pass_cnt++;
        check_cnt++;
        if (obs_mm !== 1'b0) $display("FAIL nominal_mismatch: got %b want 0", obs_mm);
        else pass_cnt++;
        check_cnt++;
        if (obs_x_ok !== 1'b1 || obs_rst_cycles !== 1)
            $display("FAIL nominal_xstream: got x_ok=%b rst_cycles=%0d want 1/1", obs_x_ok, obs_rst_cycles);
        else pass_cnt++;
        $display("nominal: pattern=%h len=6 zcap=%h cycles=%0d", pat, obs_zc, obs_cycles);
    endtask

    task automatic test_len_edges();
        logic [N-1:0] pat = N'($urandom);
        run_seq(pat, 0, pat, 1'b0, 0);
        check_cnt++;
        if (obs_timeout || obs_cycles !== 2 || obs_zc !== '0)
            $display("FAIL len0_run: got cycles=%0d zcap=%h want 2/0000", obs_cycles, obs_zc);
        else pass_cnt++;
        check_cnt++;
        if (obs_rst_cycles !== 1 || obs_x_ok !== 1'b1)
            $display("FAIL len0_pins: got rst_cycles=%0d x_ok=%b want 1/1", obs_rst_cycles, obs_x_ok);
        else pass_cnt++;
        $display("len0: pattern=%h cycles=%0d zcap=%h", pat, obs_cycles, obs_zc);

        pat = N'($urandom);
        run_seq(pat, N + 5, ~pat, 1'b0, 0);
        check_cnt++;
        if (obs_timeout || obs_cycles !== N + 4)
            $display("FAIL oversize_cycles: got %0d want %0d", obs_cycles, N + 4);
        else pass_cnt++;
        check_cnt++;
        if (obs_zc !== ref_capture(pat, N + 5) || obs_x_ok !== 1'b1)
            $display("FAIL oversize_data: got zcap=%h x_ok=%b want %h/1", obs_zc, obs_x_ok,
                     ref_capture(pat, N + 5));
        else pass_cnt++;
        $display("oversize: pattern=%h len=%0d zcap=%h cycles=%0d", pat, N + 5, obs_zc, obs_cycles);
    endtask

    task automatic test_start_busy();
        logic [N-1:0] pat1 = N'($urandom);
        logic [N-1:0] pat2 = N'($urandom);
        int k2 = 0;
        logic [N-1:0] zc2 = '0;
        run_seq(pat1, 4, pat2, 1'b1, 0);
        check_cnt++;
        if (obs_timeout || obs_cycles !== 8 || obs_zc !== ref_capture(pat1, 4))
            $display("FAIL busy_run1: got cycles=%0d zcap=%h want 8/%h", obs_cycles, obs_zc,
                     ref_capture(pat1, 4));
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_idle_gap: got busy=%b want 0", busy);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        check_cnt++;
        if (busy !== 1'b1 || dut_reset !== 1'b1)
            $display("FAIL busy_restart: got busy=%b dut_reset=%b want 1/1", busy, dut_reset);
        else pass_cnt++;
        for (int k = 2; k <= BUDGET; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k2 = k; zc2 = z_capture;
                break;
            end
        end
        check_cnt++;
        if (k2 !== 8 || zc2 !== ref_capture(pat2, 4))
            $display("FAIL busy_run2: got cycles=%0d zcap=%h want 8/%h", k2, zc2, ref_capture(pat2, 4));
        else pass_cnt++;
        $display("start_busy: pat1=%h pat2=%h zcap2=%h", pat1, pat2, zc2);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] pat = N'($urandom) | 16'h0003;
        int done_cnt = 0;
        @(negedge clk);
        pattern = pat; len = LEN_W'(8); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt++;
        if (x !== pat[3]) $display("FAIL mid_bit3: got x=%b want %b", x, pat[3]);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        check_cnt++;
        if ({busy, x, dut_reset, done} !== 4'b0 || z_capture !== '0)
            $display("FAIL mid_reset: got busy/x/dut_reset/done=%b zcap=%h want 0000/0000",
                     {busy, x, dut_reset, done}, z_capture);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check_cnt++;
        if (done_cnt !== 0) $display("FAIL mid_no_done: got %0d active cycles want 0", done_cnt);
        else pass_cnt++;
        $display("reset_mid: pattern=%h aborted at bit 3", pat);
    endtask

    task automatic test_checker();
        logic [N-1:0] exp_zc = ref_capture(16'h000F, 4) ^ 16'h0004;
        run_seq(16'h000F, 4, 16'h0000, 1'b0, 5);
        check_cnt++;
        if (obs_timeout || obs_zc !== exp_zc) $display("FAIL chk_zcap: got %h want %h", obs_zc, exp_zc);
        else pass_cnt++;
        check_cnt++;
        if (obs_mm !== CHECK_EN) $display("FAIL chk_flag: got %b want %b", obs_mm, CHECK_EN);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (mismatch !== CHECK_EN) $display("FAIL chk_sticky: got %b want %b", mismatch, CHECK_EN);
        else pass_cnt++;
        run_seq(16'h000F, 4, 16'h0000, 1'b0, 0);
        check_cnt++;
        if (obs_mm0 !== 1'b0 || obs_mm !== 1'b0 || obs_zc0 !== '0)
            $display("FAIL chk_clear: got mm_at_start=%b mm_end=%b zcap_at_start=%h want 0/0/0000",
                     obs_mm0, obs_mm, obs_zc0);
        else pass_cnt++;
        $display("checker: faulty zcap=%h, clean rerun zcap=%h", exp_zc, obs_zc);
    endtask

    task automatic test_all_ones();
        run_seq(16'hFFFF, 16, 16'h0000, 1'b0, 0);
        check_cnt++;
        if (obs_timeout || obs_zc !== 16'h5555 || obs_cycles !== 20)
            $display("FAIL all_ones: got zcap=%h cycles=%0d want 5555/20", obs_zc, obs_cycles);
        else pass_cnt++;
        $display("all_ones: zcap=%h cycles=%0d", obs_zc, obs_cycles);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [N-1:0] pat = N'($urandom);
            int l = int'($urandom_range(0, N + 3));
            run_seq(pat, l, N'($urandom), 1'b0, 0);
            check_cnt++;
            if (obs_timeout || obs_cycles !== ref_cycles(l) || obs_zc !== ref_capture(pat, l) ||
                obs_x_ok !== 1'b1 || obs_rst_cycles !== 1 || obs_mm !== 1'b0)
                $display("FAIL random_%0d: got cycles=%0d zcap=%h x_ok=%b rst=%0d mm=%b want %0d/%h/1/1/0",
                         it, obs_cycles, obs_zc, obs_x_ok, obs_rst_cycles, obs_mm,
                         ref_cycles(l), ref_capture(pat, l));
            else pass_cnt++;
            $display("random %0d: pattern=%h len=%0d zcap=%h cycles=%0d", it, pat, l, obs_zc, obs_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_len_edges();
        test_start_busy();
        test_reset_mid();
        test_checker();
        test_all_ones();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/moore_t_sequencer.md
# moore_t_sequencer

Controller that sequences the `moore_t` toggle (T flip-flop) Moore FSM. On `start`, it resets the FSM, drives a latched bit pattern onto its `x` input one bit per cycle, and captures the resulting `z` stream. It then reports completion with a one-cycle `done` pulse. It sits between a host/test controller and a `moore_t` instance, which it fully owns.

## Interface
- `N`, default 16: maximum pattern length in bits.
- `LEN_W`, default `$clog2(N+1)`: width of the length field.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — run request; sampled only in IDLE.
- `pattern`  in  N  — `x` bits, LSB driven first; latched on accepted `start`.
- `len`  in  LEN_W  — bits to drive; latched on accepted `start`; values above N saturate to N.
- `dut_reset`  out  1  — reset to `moore_t`.
- `x`  out  1  — drive to `moore_t`.
- `z`  in  1  — `moore_t` output.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse at end of run.
- `z_capture`  out  N  — captured `z`; bit i is the `z` response to pattern bit i.
- `mismatch`  out  1  — sticky per run; see Configuration.

## Operation
- **States:** IDLE, CLR, DRIVE, DRAIN, DONE.
- **IDLE:**
  - `start`=1 at an edge: latch `pattern` and `len` (saturated), clear `z_capture` and `mismatch`, go to CLR.
  - `start` in any other state is ignored; no queuing.
- **CLR:** one cycle with `dut_reset`=1, forcing `moore_t` state and `z` to 0.
  - Next state is DRIVE if latched len>0.
  - Latched len=0 goes straight to DONE; `z_capture` stays 0.
- **DRIVE:** for len cycles, `x` = latched pattern[i], with i = 0..len-1; index counter is LEN_W bits. After the last bit, go to DRAIN.
- **DRAIN:** exactly 2 cycles with `x`=0, letting the final responses arrive. Then go to DONE.
- **DONE:** one cycle with `done`=1, then IDLE.
- **Capture:**
  - A 2-stage valid/index pipeline tracks each driven bit.
  - `z` sampled at the edge two cycles after bit i was first driven is written to `z_capture[i]`.
  - Bits at index ≥ len remain 0.
- `x`=0 and `dut_reset`=0 in IDLE, DRAIN and DONE. `dut_reset`=0 in DRIVE.
- `z_capture` and `mismatch` hold their values from DONE until the next accepted `start`.

## Timing
- **Reset values:** state IDLE, `x`=0, `dut_reset`=0, `busy`=0, `done`=0, `z_capture`=0, `mismatch`=0.
- **Reset mid-run:** asynchronously returns to IDLE with the values above. The run is discarded and no `done` pulse is produced.
- All outputs are registered; `x` changes only on rising edges.
- **Cycle count:** start-accept edge to `done` high is 1 (CLR) + len (DRIVE) + 2 (DRAIN) + 1 cycles. For len=0 it is 2 cycles.
- **Response latency:** bit i is driven at edge E. `moore_t` samples it at E+1. The sequencer captures `z` at E+2.
- **Back-to-back runs:** the earliest new `start` is accepted at the edge after DONE, i.e. the first IDLE cycle.

## Configuration
- **`SEQ_CHECK_EN` defined:**
  - A reference toggle model (expected state toggles when driven bit=1, starts at 0 after CLR) runs in lockstep with the capture pipeline.
  - Any captured bit differing from the expected bit sets `mismatch`. It stays set until the next accepted `start`.
- **`SEQ_CHECK_EN` undefined:** the model is not built and `mismatch` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `moore_seq_pkg`:
  - state enum (IDLE, CLR, DRIVE, DRAIN, DONE)
  - `SEQ_DRAIN_CYCLES`=2
  - default N
- Sub-module `tff_ref_model`: expected-`z` generator with inputs `clk`, `reset`, `clr`, `en`, `t` and output `q`. It is instantiated only under `SEQ_CHECK_EN`.
- `moore_t` is instantiated by the parent or bench, not inside the sequencer.

## Test plan
- **Nominal run:** pattern=0x2D (x sequence 1,0,1,1,0,1), len=6, `z` from a correct `moore_t`.
  - `z_capture`=0x1B and `mismatch`=0.
  - `done` 10 cycles after start accept.
- **Empty and oversize lengths:**
  - len=0 → `dut_reset` pulses once, no `x` activity, `done` after 2 cycles, `z_capture`=0.
  - len=N+5 → saturates to N; N bits driven, `done` after N+4 cycles.
- **Start while busy:** `start` held high throughout a len=4 run.
  - Exactly one run executes.
  - A second run begins at the first IDLE edge after `done`, with freshly latched pattern.
- **Reset mid-DRIVE:** assert `reset` at bit 3 of a len=8 run.
  - Immediately `busy`=0, `x`=0, `z_capture`=0.
  - No `done` pulse.
- **Checker (`SEQ_CHECK_EN`):** bench forces `z` inverted during bit 2 of pattern=0x0F, len=4.
  - `mismatch`=1 at DONE and remains 1.
  - Cleared on the next start.
  - Without the macro, `mismatch` stays 0.
- **All-ones toggle:** pattern=0xFFFF, len=16 → `z_capture`=0x5555 (alternating, bit0=1).
